// File: rtl/seven_segment_pkg.sv
// Shared seven-segment definitions: active-low {g,f,e,d,c,b,a} patterns used by both the display
// driver and the capture monitor.
package seven_segment_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seven_segment_pattern_decode.sv
// Combinational reverse lookup of an active-low segment pattern to a hex nibble.
module seven_segment_pattern_decode
    import seven_segment_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic       blank,
    output logic [3:0] nibble
);

    always_comb begin
        hit    = 1'b0;
        nibble = 4'h0;
        for (int k = 0; k < 16; k++) begin
            if (seg == SEG_HEX[k]) begin
                hit    = 1'b1;
                nibble = 4'(k);
            end
        end
    end

    assign blank = (seg == SEG_BLANK);

endmodule

// File: rtl/seven_segment_capture.sv
// Monitor for a multiplexed active-low seven-segment bus: captures each settled digit strobe,
// rebuilds the four-digit value and flags malformed frames.
module seven_segment_capture
    import seven_segment_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  valid,
    output logic        frame_done,
    output logic        err
);

    localparam logic [7:0] CntMax = 8'(STABLE_CYCLES);

    logic [10:0]           sync_q, s_q, s_prev_q;
    logic [7:0]            cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0] seen_q, seen_d;
    logic [15:0]           digits_d;
    logic [3:0]            valid_d;
    logic                  err_d;
    logic                  capture;
    logic                  hit, blank;
    logic [3:0]            nibble;
    logic                  one_hot, idle;
    logic [1:0]            idx;

    seven_segment_pattern_decode u_decode (
        .seg    (s_q[6:0]),
        .hit    (hit),
        .blank  (blank),
        .nibble (nibble)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (s_q != s_prev_q) begin
            cnt_d = 8'd0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Fires only on the STABLE_CYCLES-1 -> STABLE_CYCLES step, so once per stable interval.
    assign capture = (s_q == s_prev_q) && (cnt_q == CntMax - 8'd1);

    always_comb begin
        one_hot = 1'b1;
        idx     = 2'd0;
        case (s_q[10:7])
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: one_hot = 1'b0;
        endcase
        idle = (s_q[10:7] == 4'hF);
    end

    always_comb begin
        digits_d = digits;
        valid_d  = valid;
        err_d    = 1'b0;
        // A completed mask clears here; a capture in the same cycle seeds the next frame.
        seen_d   = (seen_q == '1) ? '0 : seen_q;
        if (capture) begin
            if (one_hot) begin
                if (hit) begin
                    digits_d[{idx, 2'b00} +: 4] = nibble;
                    valid_d[idx]                = 1'b1;
                    seen_d[idx]                 = 1'b1;
                end else if (blank) begin
                    valid_d[idx] = 1'b0;
                    seen_d[idx]  = 1'b1;
                end else begin
                    valid_d[idx] = 1'b0;
                    err_d        = 1'b1;
                end
            end else if (!idle) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '1;
            s_q        <= '1;
            s_prev_q   <= '1;
            cnt_q      <= 8'd0;
            seen_q     <= '0;
            digits     <= 16'h0;
            valid      <= 4'h0;
            err        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            sync_q     <= {an, seg};
            s_q        <= sync_q;
            s_prev_q   <= s_q;
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            digits     <= digits_d;
            valid      <= valid_d;
            err        <= err_d;
            frame_done <= (seen_q == '1);
        end
    end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Randomized and directed bench for seven_segment_capture against a pin-run reference model.
module tb_seven_segment_capture;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic        frame_done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int fd_count = 0;
    int err_count = 0;

    always #5 clk = ~clk;

    seven_segment_capture #(.STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .an         (an),
        .seg        (seg),
        .digits     (digits),
        .valid      (valid),
        .frame_done (frame_done),
        .err        (err)
    );

    localparam logic [6:0] HEX_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference model state: pin-value run length plus a two-edge synchronizer delay.
    logic [15:0] m_digits;
    logic [3:0]  m_valid, m_seen;
    logic        m_fd, m_err;
    logic [10:0] m_prev;
    int          m_run;
    logic        pend_v [2];
    logic [10:0] pend_p [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_digits = 16'h0;
        m_valid  = 4'h0;
        m_seen   = 4'h0;
        m_fd     = 1'b0;
        m_err    = 1'b0;
        m_prev   = '1;
        m_run    = S + 1;
        pend_v[0] = 1'b0;
        pend_v[1] = 1'b0;
        pend_p[0] = '1;
        pend_p[1] = '1;
    endtask

    function automatic int find_hex(input logic [6:0] s);
        for (int k = 0; k < 16; k++) if (HEX_TAB[k] == s) return k;
        return -1;
    endfunction

    task automatic model_capture(input logic [10:0] p);
        logic [3:0] a;
        logic [6:0] sg;
        int         zeros, i, h;
        a = p[10:7];
        sg = p[6:0];
        zeros = $countones(~a);
        i = 0;
        for (int k = 0; k < 4; k++) if (!a[k]) i = k;
        if (zeros == 1) begin
            h = find_hex(sg);
            if (h >= 0) begin
                m_digits[i*4 +: 4] = h[3:0];
                m_valid[i] = 1'b1;
                m_seen[i]  = 1'b1;
            end else if (sg == 7'h7F) begin
                m_valid[i] = 1'b0;
                m_seen[i]  = 1'b1;
            end else begin
                m_valid[i] = 1'b0;
                m_err      = 1'b1;
            end
        end else if (zeros > 1) begin
            m_err = 1'b1;
        end
    endtask

    task automatic model_edge(input logic [10:0] p);
        logic fd, fresh;
        fd = (m_seen == 4'hF);
        if (fd) m_seen = 4'h0;
        m_err = 1'b0;
        if (pend_v[1]) model_capture(pend_p[1]);
        m_fd = fd;
        pend_v[1] = pend_v[0];
        pend_p[1] = pend_p[0];
        fresh = 1'b0;
        if (p == m_prev) begin
            if (m_run < S + 1) begin
                m_run++;
                fresh = (m_run == S + 1);
            end
        end else begin
            m_run = 1;
        end
        m_prev = p;
        pend_v[0] = fresh;
        pend_p[0] = p;
    endtask

    // Called just after an active edge: drive pins, then check right after the next edge.
    task automatic tick(input logic [3:0] a, input logic [6:0] s);
        an  = a;
        seg = s;
        @(posedge clk);
        #1;
        model_edge({a, s});
        check_eq("digits", 32'(digits), 32'(m_digits));
        check_eq("valid", 32'(valid), 32'(m_valid));
        check_eq("frame_done", 32'(frame_done), 32'(m_fd));
        check_eq("err", 32'(err), 32'(m_err));
        if (frame_done) fd_count++;
        if (err) err_count++;
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        for (int k = 0; k < n; k++) tick(a, s);
    endtask

    task automatic do_reset();
        an    = 4'hF;
        seg   = 7'h7F;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int fd0, er0, err_edge, err_hits, r, d, len;
        logic [3:0] a;
        logic [6:0] sg;

        do_reset();
        check_eq("reset_digits", 32'(digits), 32'h0);
        check_eq("reset_valid", 32'(valid), 32'h0);
        hold(4'hF, 7'h7F, 4);

        // Scan 3,7,1,9.
        fd0 = fd_count;
        er0 = err_count;
        hold(4'b1110, 7'h30, 8);
        hold(4'b1101, 7'h78, 8);
        hold(4'b1011, 7'h79, 8);
        hold(4'b0111, 7'h10, 8);
        hold(4'hF, 7'h7F, 6);
        check_eq("scan_digits", 32'(digits), 32'h9173);
        check_eq("scan_valid", 32'(valid), 32'hF);
        check_eq("scan_frames", 32'(fd_count - fd0), 32'd1);
        check_eq("scan_errs", 32'(err_count - er0), 32'd0);

        // Short glitch on digit 0 is rejected.
        hold(4'b1110, 7'h06, 3);
        hold(4'b1110, 7'h0E, 6);
        hold(4'hF, 7'h7F, 4);
        check_eq("glitch_digit0", 32'(digits[3:0]), 32'hF);

        // Two strobes at once.
        er0 = err_count;
        hold(4'b1100, 7'h40, 10);
        hold(4'hF, 7'h7F, 4);
        check_eq("multi_an_errs", 32'(err_count - er0), 32'd1);
        check_eq("multi_an_digits", 32'(digits), 32'h917F);
        check_eq("multi_an_valid", 32'(valid), 32'hF);

        // Malformed then blank on digit 2; blank still counts toward the frame.
        er0 = err_count;
        hold(4'b1011, 7'h55, 10);
        check_eq("bad_seg_errs", 32'(err_count - er0), 32'd1);
        check_eq("bad_seg_valid2", 32'(valid[2]), 32'd0);
        er0 = err_count;
        fd0 = fd_count;
        hold(4'b1011, 7'h7F, 10);
        check_eq("blank_errs", 32'(err_count - er0), 32'd0);
        check_eq("blank_valid2", 32'(valid[2]), 32'd0);
        hold(4'b1101, 7'h24, 8);
        hold(4'b0111, 7'h12, 8);
        hold(4'hF, 7'h7F, 6);
        check_eq("blank_frame", 32'(fd_count - fd0), 32'd1);

        // Mid-scan reset discards the partial frame.
        do_reset();
        hold(4'hF, 7'h7F, 4);
        hold(4'b1110, 7'h19, 8);
        hold(4'b1101, 7'h02, 8);
        hold(4'hF, 7'h7F, 3);
        #3;
        rst_n = 1'b0;
        an    = 4'hF;
        seg   = 7'h7F;
        #1;
        check_eq("async_rst_digits", 32'(digits), 32'h0);
        check_eq("async_rst_valid", 32'(valid), 32'h0);
        check_eq("async_rst_fd", 32'(frame_done), 32'h0);
        check_eq("async_rst_err", 32'(err), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        fd0 = fd_count;
        hold(4'b1011, 7'h46, 8);
        hold(4'b0111, 7'h21, 8);
        hold(4'hF, 7'h7F, 6);
        check_eq("partial_frame", 32'(fd_count - fd0), 32'd0);

        // Long hold: exactly one capture, landing on edge STABLE_CYCLES+2.
        err_edge = -1;
        err_hits = 0;
        for (int i = 0; i < 100; i++) begin
            tick(4'b1101, 7'h55);
            if (err) begin
                err_hits++;
                if (err_edge < 0) err_edge = i;
            end
        end
        check_eq("hold_captures", 32'(err_hits), 32'd1);
        check_eq("hold_edge", 32'(err_edge), 32'(S + 2));
        hold(4'hF, 7'h7F, 4);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            d = int'($urandom_range(0, 3));
            a = 4'(~(4'b0001 << d));
            if (r < 6) begin
                sg = HEX_TAB[$urandom_range(0, 15)];
            end else if (r == 6) begin
                sg = 7'h7F;
            end else if (r == 7) begin
                sg = 7'($urandom);
            end else if (r == 8) begin
                a  = 4'($urandom);
                sg = HEX_TAB[$urandom_range(0, 15)];
            end else begin
                a  = 4'hF;
                sg = 7'($urandom);
            end
            len = int'($urandom_range(1, 9));
            hold(a, sg, len);
        end
        hold(4'hF, 7'h7F, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
